// File: rtl/memory_arbiter_pkg.sv
// Shared types and helpers for the unified-RAM arbiter between fetch and load/store.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_IBUSY, ARB_DBUSY} arb_state_t;
  typedef enum logic {ARB_FETCH, ARB_DATA} arb_kind_t;

  typedef logic [31:0] u32_t;

  // Saturating increment used by the fetch starvation counter.
  function automatic u32_t sat_inc(u32_t v, u32_t lim);
    return (v < lim) ? v + 32'd1 : lim;
  endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates one RAM port between instruction fetch and data accesses. Data has
// priority, but a fetch waiting through STARVE_LIMIT data grants wins the next slot.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  arb_state_t        r_state;
  arb_kind_t         r_kind;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_write;
  logic [SW-1:0]     r_starve;

  logic w_dreq, w_fetch_win, w_data_win, w_busy;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= ARB_IDLE;
      r_kind   <= ARB_FETCH;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_write  <= 1'b0;
      r_starve <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_fetch_win) begin
            r_state  <= ARB_IBUSY;
            r_kind   <= ARB_FETCH;
            r_addr   <= iaddr;
            r_wdata  <= '0;
            r_write  <= 1'b0;
            r_starve <= '0;
          end else if (w_data_win) begin
            r_state  <= ARB_DBUSY;
            r_kind   <= ARB_DATA;
            r_addr   <= daddr;
            r_wdata  <= dstore;
            // A combined read+write request performs the write.
            r_write  <= dWEN;
            r_starve <= iREN ? SW'(sat_inc(u32_t'(r_starve), u32_t'(STARVE_LIMIT))) : '0;
          end else if (!iREN) begin
            r_starve <= '0;
          end
        end
        ARB_IBUSY, ARB_DBUSY: begin
          // The RAM cannot abort, so even a dropped requester waits for ram_ready.
          if (ram_ready) r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    w_dreq      = dREN | dWEN;
    w_fetch_win = iREN & (~w_dreq | (r_starve >= LIMIT));
    w_data_win  = w_dreq & ~w_fetch_win;
    w_busy      = (r_state == ARB_IBUSY) || (r_state == ARB_DBUSY);

    // RAM side is driven only from latched grant state.
    ram_ren   = w_busy & ~r_write;
    ram_wen   = w_busy & r_write;
    ram_addr  = w_busy ? r_addr : '0;
    ram_wdata = (w_busy & r_write) ? r_wdata : '0;

    ihit  = w_busy & (r_kind == ARB_FETCH) & ram_ready & iREN;
    dhit  = w_busy & (r_kind == ARB_DATA) & ram_ready & w_dreq;
    iload = ihit ? ram_rdata : '0;
    dload = dhit ? ram_rdata : '0;
  end

endmodule
